reloj_bus_scanner: RTL and testbench
====================================

Name: reloj_bus_scanner

Overview:
- Controller and sequencer for the 6-digit 24 h clock read bus, which has a 3-bit address and a 4-bit data bus.
- Walks address codes 0..5 (Us, Ds, Um, Dm, Uh, Dh) and captures each digit after the bus latency.
- Rejects torn reads caused by a rollover mid-sweep, then commits a coherent 24-bit time snapshot.
- Serves snapshots to a request/ack client and to a built-in 6-digit multiplexed display driver.

Parameters:
- BUS_LAT, 1: clock cycles from a direccion change to valid data on bus_in (1..3).
- MAX_RETRY, 3: maximum re-sweeps after a torn read before committing with the error flag set.
- REFRESH_DIV, 1000: clk cycles per display digit slot (>=2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- direccion  out  3  digit address to the clock bus; 3'b111 when idle.
- bus_in  in  4  digit data returned by the clock bus.
- cont  in  1  1 = free-running sweeps back to back; 0 = sweep only on request.
- snap_req  in  1  snapshot request, level, held until snap_ack.
- snap_ack  out  1  one-cycle pulse: snapshot committed for the pending request.
- snap_valid  out  1  one-cycle pulse on every commit.
- snapshot  out  24  {Dh,Uh,Dm,Um,Ds,Us}, 4 bits per digit, BCD.
- snap_err  out  1  set on commit if the snapshot failed the range check or exhausted retries.
- an  out  6  one-hot digit enable, active high; an[0] = Us.
- seg_digit  out  4  BCD value of the currently enabled digit.

Behaviour:
- Reset (rst_n=0 at an edge) values:
  - direccion=3'b111, snapshot=0, snap_ack=0, snap_valid=0, snap_err=0.
  - an=6'b000001, seg_digit=0.
  - FSM to IDLE; retry count, pending flag and refresh counter cleared.
- Reset asserted mid-sweep aborts the sweep; the partial capture is discarded.
- FSM states: IDLE, ADDR, WAIT, CAPT, VERIFY_ADDR, VERIFY_WAIT, VERIFY_CAPT, COMMIT.
- IDLE -> ADDR when (snap_req & ~snap_ack) or cont. The digit index resets to 0.
- ADDR: drive direccion=index for 1 cycle, then WAIT.
- WAIT: hold BUS_LAT cycles, then CAPT.
- CAPT: store bus_in into shadow[index], then:
  - if index<5, index+1 and go to ADDR;
  - otherwise go to VERIFY_ADDR.
- Per-digit cost is BUS_LAT+2 cycles. direccion holds its value through WAIT and CAPT.
- Width masks applied on capture: Ds and Dm keep bits[2:0], Dh keeps bits[1:0], upper bits forced to 0.
- VERIFY_ADDR, VERIFY_WAIT and VERIFY_CAPT re-read address 0 with the same timing. The sweep is torn if the re-read Us differs from shadow[0]:
  - torn and retry<MAX_RETRY: retry+1, re-enter ADDR with index 0;
  - torn and retry==MAX_RETRY: go to COMMIT with the error flag set;
  - not torn: go to COMMIT.
- COMMIT (1 cycle):
  - snapshot<=shadow; snap_valid=1; retry<=0.
  - snap_err<=(retries exhausted) | range fault.
  - Range fault: any units digit >9, Ds or Dm >5, Dh >2, or Dh==2 with Uh>3.
  - Next state: ADDR if cont, else IDLE.
- Fault-free request latency: snap_ack and snap_valid are high 7*(BUS_LAT+2)+1 cycles after the edge that samples snap_req in IDLE. That is 22 cycles for BUS_LAT=1.
- Requests during a sweep:
  - snap_req rising during a sweep sets the pending flag.
  - The ack goes to the first commit of a sweep that started after the request was seen, never the in-flight sweep.
  - With cont=1 and snap_req already high at sweep start, the ack goes to that sweep's commit.
- snap_ack is never asserted when snap_req is low. Deasserting snap_req before the ack cancels the pending flag.
- Display:
  - The refresh counter wraps at REFRESH_DIV-1. On wrap, an rotates left (an[5] -> an[0]).
  - seg_digit = snapshot nibble selected by an, registered in the same cycle an changes.
  - A new snapshot appears on the next digit slot; the display never shows shadow registers.
- direccion returns to 3'b111 in IDLE. Unmapped codes 6 and 7 are never issued during a sweep.

Decomposition:
- Shared package reloj_pkg:
  - digit address constants ADDR_US..ADDR_DH = 0..5 and ADDR_IDLE = 7;
  - the FSM state enum;
  - digit width and limit constants (9, 5, 2, 3);
  - snapshot nibble index constants.
- Sub-module reloj_display_mux contains the refresh counter, the an rotation and the seg_digit select. Its inputs are clk, rst_n and snapshot.

Test Plan:
- Bus model with BUS_LAT=1, time fixed at 13:47:52, cont=0. Pulse snap_req -> snap_ack at +22 cycles, snapshot=24'h134752, snap_err=0, direccion sequence 0,1,2,3,4,5,0,7.
- Us changes 2->3 between the first read and the verify read, then stable at 13:47:53 -> one retry; commit at +43 cycles; snapshot=24'h134753, snap_err=0.
- Us changes on every sweep, MAX_RETRY=3 -> commit after 4 sweeps with snap_err=1, retry cleared to 0.
- Model returns Dh=2, Uh=5 (25:xx) -> commit with snap_err=1; snapshot holds 0x25 in the upper byte.
- cont=1 -> snap_valid every 22 cycles. snap_req raised mid-sweep -> ack on the second following commit. rst_n low at cycle 10 of a sweep -> all outputs at reset values, snapshot stays 0.
- REFRESH_DIV=4 with snapshot 24'h235959 -> an cycles 000001..100000 every 4 cycles; seg_digit sequence 9,5,9,5,3,2.

Source files
------------

// File: rtl/reloj_pkg.sv
// rtl/reloj_pkg.sv - shared constants, state type and digit helpers for the clock bus scanner
package reloj_pkg;

    localparam logic [2:0] ADDR_US   = 3'd0;
    localparam logic [2:0] ADDR_DS   = 3'd1;
    localparam logic [2:0] ADDR_UM   = 3'd2;
    localparam logic [2:0] ADDR_DM   = 3'd3;
    localparam logic [2:0] ADDR_UH   = 3'd4;
    localparam logic [2:0] ADDR_DH   = 3'd5;
    localparam logic [2:0] ADDR_IDLE = 3'd7;

    localparam int NUM_DIGITS = 6;

    localparam logic [3:0] UNITS_MAX    = 4'd9;
    localparam logic [3:0] TENS_MAX     = 4'd5;
    localparam logic [3:0] DH_MAX       = 4'd2;
    localparam logic [3:0] UH_MAX_AT_20 = 4'd3;

    localparam int NIB_US = 0;
    localparam int NIB_DS = 1;
    localparam int NIB_UM = 2;
    localparam int NIB_DM = 3;
    localparam int NIB_UH = 4;
    localparam int NIB_DH = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CAPT   = 3'd3,
        ST_VADDR  = 3'd4,
        ST_VWAIT  = 3'd5,
        ST_VCAPT  = 3'd6,
        ST_COMMIT = 3'd7
    } state_e;

    // Tens digits only carry as many bits as their range needs; the rest are forced low.
    function automatic logic [3:0] digit_mask(input logic [2:0] idx, input logic [3:0] raw);
        case (idx)
            ADDR_US, ADDR_UM, ADDR_UH: return raw;
            ADDR_DS, ADDR_DM:          return {1'b0, raw[2:0]};
            ADDR_DH:                   return {2'b00, raw[1:0]};
            default:                   return 4'd0;
        endcase
    endfunction

    // True when the snapshot is not a legal 24 h time.
    function automatic logic range_fault(input logic [23:0] s);
        logic [3:0] us, ds, um, dm, uh, dh;
        us = s[NIB_US*4 +: 4];
        ds = s[NIB_DS*4 +: 4];
        um = s[NIB_UM*4 +: 4];
        dm = s[NIB_DM*4 +: 4];
        uh = s[NIB_UH*4 +: 4];
        dh = s[NIB_DH*4 +: 4];
        return (us > UNITS_MAX) || (um > UNITS_MAX) || (uh > UNITS_MAX) ||
               (ds > TENS_MAX)  || (dm > TENS_MAX)  || (dh > DH_MAX)    ||
               ((dh == DH_MAX) && (uh > UH_MAX_AT_20));
    endfunction

endpackage

// File: rtl/reloj_display_mux.sv
// rtl/reloj_display_mux.sv - six-digit multiplexed display driver fed from the committed snapshot
module reloj_display_mux #(
    parameter int REFRESH_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] snapshot,
    output logic [5:0]  an,
    output logic [3:0]  seg_digit
);
    import reloj_pkg::*;

    localparam int CW = $clog2(REFRESH_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    an_q, an_d;
    logic [3:0]    seg_q, seg_d;

    // Advance the slot counter; on wrap move to the next digit and latch its nibble alongside.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        an_d  = an_q;
        seg_d = seg_q;
        if (cnt_q == CW'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            an_d  = {an_q[4:0], an_q[5]};
            case (an_d)
                6'b000001: seg_d = snapshot[NIB_US*4 +: 4];
                6'b000010: seg_d = snapshot[NIB_DS*4 +: 4];
                6'b000100: seg_d = snapshot[NIB_UM*4 +: 4];
                6'b001000: seg_d = snapshot[NIB_DM*4 +: 4];
                6'b010000: seg_d = snapshot[NIB_UH*4 +: 4];
                6'b100000: seg_d = snapshot[NIB_DH*4 +: 4];
                default:   seg_d = 4'd0;
            endcase
        end
    end

    // Display state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            an_q  <= 6'b000001;
            seg_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an        = an_q;
    assign seg_digit = seg_q;

endmodule

// File: rtl/reloj_bus_scanner.sv
// rtl/reloj_bus_scanner.sv - sweeps the clock read bus, rejects torn reads, commits coherent snapshots
module reloj_bus_scanner #(
    parameter int BUS_LAT     = 1,
    parameter int MAX_RETRY   = 3,
    parameter int REFRESH_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [2:0]  direccion,
    input  logic [3:0]  bus_in,
    input  logic        cont,
    input  logic        snap_req,
    output logic        snap_ack,
    output logic        snap_valid,
    output logic [23:0] snapshot,
    output logic        snap_err,
    output logic [5:0]  an,
    output logic [3:0]  seg_digit
);
    import reloj_pkg::*;

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    state_e        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [1:0]    wait_q, wait_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          exhaust_q, exhaust_d;
    logic [23:0]   shadow_q, shadow_d;
    logic [2:0]    dir_q, dir_d;
    logic [23:0]   snap_q, snap_d;
    logic          ack_q, ack_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          pending_q, pending_d;
    logic          armed_q, armed_d;

    logic          sweep_start;
    logic          commit;
    logic          ack_now;
    logic          req_new;

    // Sweep sequencer, torn-read check and commit, plus request bookkeeping.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        retry_d     = retry_q;
        exhaust_d   = exhaust_q;
        shadow_d    = shadow_q;
        dir_d       = dir_q;
        snap_d      = snap_q;
        valid_d     = 1'b0;
        err_d       = err_q;
        sweep_start = 1'b0;
        commit      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cont || (snap_req && !ack_q)) begin
                    state_d     = ST_ADDR;
                    idx_d       = 3'd0;
                    sweep_start = 1'b1;
                end
            end
            ST_ADDR: begin
                state_d = ST_WAIT;
                wait_d  = 2'd0;
            end
            ST_WAIT: begin
                if (wait_q == 2'(BUS_LAT - 1)) state_d = ST_CAPT;
                else                           wait_d  = wait_q + 2'd1;
            end
            ST_CAPT: begin
                shadow_d[idx_q*4 +: 4] = digit_mask(idx_q, bus_in);
                if (idx_q == 3'(NUM_DIGITS - 1)) begin
                    state_d = ST_VADDR;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = ST_ADDR;
                end
            end
            ST_VADDR: begin
                state_d = ST_VWAIT;
                wait_d  = 2'd0;
            end
            ST_VWAIT: begin
                if (wait_q == 2'(BUS_LAT - 1)) state_d = ST_VCAPT;
                else                           wait_d  = wait_q + 2'd1;
            end
            ST_VCAPT: begin
                // A units-of-seconds change since the first read means the sweep straddled a rollover.
                if (bus_in != shadow_q[NIB_US*4 +: 4]) begin
                    if (retry_q == RW'(MAX_RETRY)) begin
                        exhaust_d = 1'b1;
                        state_d   = ST_COMMIT;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        idx_d   = 3'd0;
                        state_d = ST_ADDR;
                    end
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit    = 1'b1;
                snap_d    = shadow_q;
                valid_d   = 1'b1;
                err_d     = exhaust_q | range_fault(shadow_q);
                retry_d   = '0;
                exhaust_d = 1'b0;
                if (cont) begin
                    state_d     = ST_ADDR;
                    idx_d       = 3'd0;
                    sweep_start = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // direccion is registered and changes only when a new address phase begins or the bus goes idle.
        case (state_d)
            ST_ADDR:  dir_d = idx_d;
            ST_VADDR: dir_d = ADDR_US;
            ST_IDLE:  dir_d = ADDR_IDLE;
            default:  dir_d = dir_q;
        endcase

        // A request is served only by a sweep that began after it was seen; the tail of an
        // already-acknowledged request never re-arms.
        ack_now = commit && armed_q && snap_req;
        ack_d   = ack_now;
        req_new = snap_req && !ack_q && !ack_now;
        armed_d = armed_q && snap_req && !commit;
        if (sweep_start) armed_d = (pending_q && snap_req) || req_new;
        pending_d = req_new && !armed_d && (state_d != ST_IDLE);
    end

    // Scanner state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 3'd0;
            wait_q    <= 2'd0;
            retry_q   <= '0;
            exhaust_q <= 1'b0;
            shadow_q  <= 24'd0;
            dir_q     <= ADDR_IDLE;
            snap_q    <= 24'd0;
            ack_q     <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            pending_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
            retry_q   <= retry_d;
            exhaust_q <= exhaust_d;
            shadow_q  <= shadow_d;
            dir_q     <= dir_d;
            snap_q    <= snap_d;
            ack_q     <= ack_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            pending_q <= pending_d;
            armed_q   <= armed_d;
        end
    end

    assign direccion  = dir_q;
    assign snapshot   = snap_q;
    assign snap_ack   = ack_q;
    assign snap_valid = valid_q;
    assign snap_err   = err_q;

    reloj_display_mux #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_display (
        .clk       (clk),
        .rst_n     (rst_n),
        .snapshot  (snap_q),
        .an        (an),
        .seg_digit (seg_digit)
    );

endmodule

// File: tb/tb_reloj_bus_scanner.sv
// tb/tb_reloj_bus_scanner.sv - directed bench with bus model and request scoreboard
module tb_reloj_bus_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  direccion;
    logic [3:0]  bus_in;
    logic        cont = 1'b0;
    logic        snap_req = 1'b0;
    logic        snap_ack;
    logic        snap_valid;
    logic [23:0] snapshot;
    logic        snap_err;
    logic [5:0]  an;
    logic [3:0]  seg_digit;

    always #5 clk = ~clk;

    reloj_bus_scanner #(
        .BUS_LAT     (1),
        .MAX_RETRY   (3),
        .REFRESH_DIV (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .direccion  (direccion),
        .bus_in     (bus_in),
        .cont       (cont),
        .snap_req   (snap_req),
        .snap_ack   (snap_ack),
        .snap_valid (snap_valid),
        .snapshot   (snapshot),
        .snap_err   (snap_err),
        .an         (an),
        .seg_digit  (seg_digit)
    );

    // Clock bus model: one cycle from address to data.
    logic [3:0] digits [8];
    logic [2:0] dir_dly;
    always @(posedge clk) dir_dly <= direccion;
    assign bus_in = digits[dir_dly];

    typedef struct {
        logic [23:0] snap;
        logic        err;
        int          lat;
    } exp_t;

    exp_t       sb[$];
    logic [2:0] dir_log[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_time(input logic [23:0] t);
        for (int i = 0; i < 6; i++) digits[i] = t[4*i +: 4];
    endtask

    task automatic do_request(input string tag, input logic [23:0] t, input logic [23:0] exp_snap,
                              input logic exp_err, input int exp_lat, input int tear_every,
                              input int tear_at, input logic [3:0] tear_val);
        exp_t       e;
        exp_t       got_e;
        int         edges;
        int         v;
        logic       got;
        logic [2:0] last_dir;
        set_time(t);
        e.snap = exp_snap;
        e.err  = exp_err;
        e.lat  = exp_lat;
        sb.push_back(e);
        @(negedge clk);
        snap_req = 1'b1;
        edges    = -1;
        got      = 1'b0;
        dir_log.delete();
        last_dir = direccion;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (tear_every > 0 && edges > 0 && (edges % tear_every) == 0) begin
                v = int'(digits[0]);
                v = (v + 1) % 10;
                digits[0] = 4'(v);
            end
            if (edges == tear_at) digits[0] = tear_val;
            if (direccion != last_dir) begin
                dir_log.push_back(direccion);
                last_dir = direccion;
            end
            if (snap_ack) begin
                got = 1'b1;
                break;
            end
        end
        snap_req = 1'b0;
        check({tag, "_ack_seen"}, 32'(got), 32'd1);
        got_e = sb.pop_front();
        if (got) begin
            check({tag, "_latency"}, 32'(edges), 32'(got_e.lat));
            check({tag, "_valid"}, 32'(snap_valid), 32'd1);
            check({tag, "_snapshot"}, 32'(snapshot), 32'(got_e.snap));
            check({tag, "_err"}, 32'(snap_err), 32'(got_e.err));
        end
    endtask

    task automatic wait_valid(input int budget, output logic got, output int edges);
        got   = 1'b0;
        edges = 0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (snap_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic [2:0] exp_dir [8];
        logic [3:0] exp_seg [6];
        logic [5:0] prev_an;
        logic [5:0] exp_an;
        logic       got;
        int         edges;
        int         nvalid;
        exp_t       e;

        exp_dir = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd7};
        exp_seg = '{4'd9, 4'd5, 4'd9, 4'd5, 4'd3, 4'd2};
        digits[6] = 4'hF;
        digits[7] = 4'hF;
        set_time(24'h134752);

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_direccion", 32'(direccion), 32'd7);
        check("rst_snapshot", 32'(snapshot), 32'd0);
        check("rst_ack", 32'(snap_ack), 32'd0);
        check("rst_valid", 32'(snap_valid), 32'd0);
        check("rst_err", 32'(snap_err), 32'd0);
        check("rst_an", 32'(an), 32'h01);
        check("rst_seg", 32'(seg_digit), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset in the middle of a sweep discards the partial capture.
        snap_req = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_in_sweep_dir", 32'(direccion), 32'd3);
        rst_n    = 1'b0;
        snap_req = 1'b0;
        @(negedge clk);
        check("midrst_direccion", 32'(direccion), 32'd7);
        check("midrst_snapshot", 32'(snapshot), 32'd0);
        check("midrst_ack", 32'(snap_ack), 32'd0);
        check("midrst_valid", 32'(snap_valid), 32'd0);
        check("midrst_err", 32'(snap_err), 32'd0);
        check("midrst_an", 32'(an), 32'h01);
        rst_n  = 1'b1;
        nvalid = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (snap_valid) nvalid++;
        end
        check("midrst_no_commit", 32'(nvalid), 32'd0);
        check("midrst_snapshot_after", 32'(snapshot), 32'd0);

        // Clean request at 13:47:52.
        do_request("clean", 24'h134752, 24'h134752, 1'b0, 22, 0, -1, 4'd0);
        check("clean_dir_count", 32'(dir_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < dir_log.size()) check($sformatf("clean_dir_%0d", i), 32'(dir_log[i]), 32'(exp_dir[i]));
        end
        repeat (5) @(negedge clk);

        // Us keeps changing: all retries used, commit flagged.
        do_request("exhaust", 24'h134752, 24'h134751, 1'b1, 85, 7, -1, 4'd0);
        repeat (5) @(negedge clk);

        // One tear, then stable: retry counter must have been cleared by the previous commit.
        do_request("tear_once", 24'h134752, 24'h134753, 1'b0, 43, 0, 10, 4'd3);
        repeat (5) @(negedge clk);

        // 25:10:00 is out of range.
        do_request("range", 24'h251000, 24'h251000, 1'b1, 22, 0, -1, 4'd0);
        repeat (5) @(negedge clk);

        // 23:59:59 then the display rotation.
        do_request("max_time", 24'h235959, 24'h235959, 1'b0, 22, 0, -1, 4'd0);
        repeat (24) @(negedge clk);
        got     = 1'b0;
        prev_an = an;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (an == 6'b000001 && prev_an == 6'b100000) begin
                got = 1'b1;
                break;
            end
            prev_an = an;
        end
        check("disp_sync", 32'(got), 32'd1);
        if (got) begin
            for (int k = 0; k < 6; k++) begin
                if (k > 0) repeat (4) @(negedge clk);
                exp_an = 6'(1 << k);
                check($sformatf("disp_an_%0d", k), 32'(an), 32'(exp_an));
                check($sformatf("disp_seg_%0d", k), 32'(seg_digit), 32'(exp_seg[k]));
            end
        end

        // Continuous sweeps, with a request raised mid-sweep.
        set_time(24'h120000);
        @(negedge clk);
        cont = 1'b1;
        wait_valid(100, got, edges);
        check("cont_first_commit", 32'(got), 32'd1);
        wait_valid(100, got, edges);
        check("cont_second_commit", 32'(got), 32'd1);
        check("cont_period", 32'(edges), 32'd22);
        repeat (10) @(negedge clk);
        e.snap = 24'h120000;
        e.err  = 1'b0;
        e.lat  = 0;
        sb.push_back(e);
        snap_req = 1'b1;
        wait_valid(100, got, edges);
        check("cont_inflight_commit", 32'(got), 32'd1);
        check("cont_inflight_no_ack", 32'(snap_ack), 32'd0);
        wait_valid(100, got, edges);
        check("cont_next_commit", 32'(got), 32'd1);
        check("cont_next_period", 32'(edges), 32'd22);
        e = sb.pop_front();
        check("cont_ack", 32'(snap_ack), 32'd1);
        check("cont_snapshot", 32'(snapshot), 32'(e.snap));
        check("cont_err", 32'(snap_err), 32'(e.err));
        snap_req = 1'b0;
        cont     = 1'b0;
        nvalid   = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (snap_ack) nvalid++;
        end
        check("cont_no_extra_ack", 32'(nvalid), 32'd0);
        check("cont_back_idle", 32'(direccion), 32'd7);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
